srrc_tx_sequencer: RTL and testbench

//  Sequences one SRRC pulse-shaping filter (2-bit Din, 18-bit Dout, clocked every cycle) for one I or Q rail.

---
 rtl/srrc_tx_sequencer.sv | 165 ++++++++++++++++
 tb/tb_srrc_tx_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/srrc_tx_sequencer.sv
// Feeds one SRRC filter for a single I/Q rail: symbol pull, zero-insertion up-sampling,
// frame slots, tail flush and output tagging. Optional sticky underrun flag: SRRC_SEQ_UNDERRUN_EN.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | one cycle holding the SRRC in reset to clear its history
// RUN     | symbol slots, OSR samples each, symbol only on phase 0
// FLUSH   | NTAPS-1 zero samples to push out the filter tail
// DRAIN   | LAT cycles letting the last sample reach srrc_dout
module srrc_tx_sequencer #(
   parameter int OSR       = 4,
   parameter int NTAPS     = 33,
   parameter int LAT       = 1,
   parameter int FRAME_LEN = 512,
   parameter int DW        = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          sym_valid,
   input  logic [1:0]    sym_data,
   output logic          sym_ready,
   output logic          srrc_rst,
   output logic [1:0]    srrc_din,
   input  logic [DW-1:0] srrc_dout,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
`ifdef SRRC_SEQ_UNDERRUN_EN
   ,
   output logic          underrun
`endif
);

   localparam int PW   = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int SW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int TMAX = (NTAPS > LAT) ? NTAPS : LAT;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [SW-1:0]   slot_q, slot_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            done_q, done_d;
   logic [LAT-1:0]  act_dly_q;
   logic [LAT-1:0]  last_dly_q;
   logic            run_ph0;
   logic            active;
   logic            last_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         slot_q  <= '0;
         tcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         slot_q  <= slot_d;
         tcnt_q  <= tcnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      slot_d  = slot_q;
      tcnt_d  = tcnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLR;
         end
         S_CLR: begin
            state_d = S_RUN;
            phase_d = '0;
            slot_d  = '0;
         end
         S_RUN: begin
            if (phase_q == PW'(OSR - 1)) begin
               phase_d = '0;
               if (slot_q == SW'(FRAME_LEN - 1)) begin
                  state_d = S_FLUSH;
                  slot_d  = '0;
                  tcnt_d  = TW'(NTAPS - 2);
               end else begin
                  slot_d = slot_q + SW'(1);
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_FLUSH: begin
            if (tcnt_q == '0) begin
               state_d = S_DRAIN;
               tcnt_d  = TW'(LAT - 1);
            end else begin
               tcnt_d = tcnt_q - TW'(1);
            end
         end
         S_DRAIN: begin
            if (tcnt_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               tcnt_d = tcnt_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign run_ph0 = (state_q == S_RUN) && (phase_q == '0);
   assign active  = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign last_in = (state_q == S_FLUSH) && (tcnt_q == '0);

   // active/last ride alongside the sample through the filter's latency
   always_ff @(posedge clk) begin
      if (reset) begin
         act_dly_q  <= '0;
         last_dly_q <= '0;
      end else begin
         act_dly_q[0]  <= active;
         last_dly_q[0] <= last_in;
         for (int i = 1; i < LAT; i++) begin
            act_dly_q[i]  <= act_dly_q[i-1];
            last_dly_q[i] <= last_dly_q[i-1];
         end
      end
   end

   // Outputs are forced to their idle values in the reset cycle itself
   assign sym_ready = run_ph0 & ~reset;
   assign srrc_din  = (sym_ready && sym_valid && (sym_data != 2'b10)) ? sym_data : 2'b00;
   assign srrc_rst  = reset | (state_q == S_CLR);
   assign out_valid = act_dly_q[LAT-1] & ~reset;
   assign out_last  = last_dly_q[LAT-1] & ~reset;
   assign out_data  = srrc_dout;
   assign busy      = (state_q != S_IDLE) & ~reset;
   assign done      = done_q & ~reset;

`ifdef SRRC_SEQ_UNDERRUN_EN
   always_ff @(posedge clk) begin
      if (reset || (state_q == S_CLR)) begin
         underrun <= 1'b0;
      end else if (run_ph0 && !sym_valid) begin
         underrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_srrc_tx_sequencer.sv
// Self-checking bench for srrc_tx_sequencer: a frame-timeline model (cycle offset from CLR)
// predicts every output each cycle; per-frame counts are pinned with hand-computed literals.
module tb_srrc_tx_sequencer;

   localparam int OSR = 4, NTAPS = 33, LAT = 1, FLEN = 8, DW = 18;
   localparam int RUNL = FLEN * OSR;
   localparam int FL   = NTAPS - 1;
   localparam int LASTK = RUNL + FL + LAT;
   localparam int ENDK  = 1 + RUNL + FL + LAT;

   logic          clk = 1'b0;
   logic          reset, start, sym_valid;
   logic [1:0]    sym_data;
   logic          sym_ready, srrc_rst;
   logic [1:0]    srrc_din;
   logic [DW-1:0] srrc_dout;
   logic          out_valid, out_last, busy, done;
   logic [DW-1:0] out_data;
`ifdef SRRC_SEQ_UNDERRUN_EN
   logic          underrun;
   bit            und_m = 1'b0;
`endif

   srrc_tx_sequencer #(.OSR(OSR), .NTAPS(NTAPS), .LAT(LAT), .FRAME_LEN(FLEN), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .sym_valid(sym_valid), .sym_data(sym_data),
      .sym_ready(sym_ready), .srrc_rst(srrc_rst), .srrc_din(srrc_din), .srrc_dout(srrc_dout),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef SRRC_SEQ_UNDERRUN_EN
      , .underrun(underrun)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int n_valid, n_last, n_done, n_xfer, n_slot, n_din_nz;
   logic [1:0] first_din;

   // model: in_frame with k = cycles since the CLR cycle (k==0 is CLR, k==ENDK is the done cycle)
   bit in_frame = 1'b0;
   int k = 0;
   bit e_rdy, e_busy, e_ov, e_ol, e_done, e_rst;
   logic [1:0] e_din;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit exp_ready();
      return !reset && in_frame && k >= 1 && k <= RUNL && ((k - 1) % OSR) == 0;
   endfunction

   always @(posedge clk) begin
`ifdef SRRC_SEQ_UNDERRUN_EN
      if (reset || (in_frame && k == 0)) und_m = 1'b0;
      else if (exp_ready() && !sym_valid) und_m = 1'b1;
`endif
      if (reset) in_frame = 1'b0;
      else if ((!in_frame || k == ENDK) && start) begin
         in_frame = 1'b1;
         k = 0;
      end else if (in_frame) begin
         k++;
         if (k > ENDK) in_frame = 1'b0;
      end
   end

   always @(negedge clk) begin
      e_rdy  = exp_ready();
      e_din  = (e_rdy && sym_valid && sym_data != 2'b10) ? sym_data : 2'b00;
      e_busy = !reset && in_frame && k < ENDK;
      e_ov   = !reset && in_frame && k >= 1 + LAT && k <= LASTK;
      e_ol   = !reset && in_frame && k == LASTK;
      e_done = !reset && in_frame && k == ENDK;
      e_rst  = reset || (in_frame && k == 0);
      check("sym_ready", 32'(sym_ready), 32'(e_rdy));
      check("srrc_din",  32'(srrc_din),  32'(e_din));
      check("busy",      32'(busy),      32'(e_busy));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("out_last",  32'(out_last),  32'(e_ol));
      check("done",      32'(done),      32'(e_done));
      check("srrc_rst",  32'(srrc_rst),  32'(e_rst));
      check("out_data",  32'(out_data),  32'(srrc_dout));
`ifdef SRRC_SEQ_UNDERRUN_EN
      check("underrun",  32'(underrun),  32'(und_m));
`endif
      if (out_valid) n_valid++;
      if (out_last) n_last++;
      if (done) n_done++;
      if (sym_valid && sym_ready) n_xfer++;
      if (sym_ready) begin
         if (n_slot == 0) first_din = srrc_din;
         n_slot++;
      end
      if (srrc_din != 2'b00) n_din_nz++;
   end

   always @(posedge clk) begin
      #1 srrc_dout = DW'($urandom);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      n_valid = 0; n_last = 0; n_done = 0; n_xfer = 0; n_slot = 0; n_din_nz = 0;
      first_din = 2'b00;
   endtask

   // mode 0 impulse, 1 underrun at slot 3, 2 start noise while busy, 3 start held, 4 random symbols
   task automatic run_frame(input int mode, input int tgt, input int budget);
      int cyc = 0;
      start = 1'b1;
      sym_valid = 1'b1;
      sym_data = 2'b01;
      while (n_done < tgt && cyc < budget) begin
         tick();
         cyc++;
         case (mode)
            0: begin start = 1'b0; sym_valid = 1'b1; sym_data = (n_xfer == 0) ? 2'b01 : 2'b00; end
            1: begin start = 1'b0; sym_valid = !(in_frame && k == 1 + 3 * OSR); sym_data = 2'($urandom); end
            2: begin start = (n_last == 0) ? 1'($urandom) : 1'b0; sym_valid = 1'b1; sym_data = 2'($urandom); end
            3: begin start = (n_last < tgt); sym_valid = 1'b1; sym_data = 2'($urandom); end
            default: begin start = 1'b0; sym_valid = ($urandom % 5) != 0; sym_data = 2'($urandom); end
         endcase
      end
      start = 1'b0;
      sym_valid = 1'b0;
      check("done_wait", n_done, tgt);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_data = 2'b00; srrc_dout = '0;
      clr_cnt();
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_srrc_rst", 32'(srrc_rst), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      reset = 1'b0;
      repeat (3) tick();

      clr_cnt();
      run_frame(0, 1, 200);
      check("imp_samples", n_valid, 64);
      check("imp_last", n_last, 1);
      check("imp_xfer", n_xfer, 8);
      check("imp_first_din", 32'(first_din), 1);
      check("imp_din_nonzero", n_din_nz, 1);
      repeat (4) tick();

      clr_cnt();
      run_frame(1, 1, 200);
      check("und_samples", n_valid, 64);
      check("und_xfer", n_xfer, 7);
      check("und_slots", n_slot, 8);
`ifdef SRRC_SEQ_UNDERRUN_EN
      check("und_flag", 32'(underrun), 1);
`endif
      repeat (4) tick();

      clr_cnt();
      run_frame(2, 1, 200);
      check("noise_done", n_done, 1);
      check("noise_samples", n_valid, 64);
      repeat (4) tick();

      clr_cnt();
      start = 1'b1; sym_valid = 1'b1; sym_data = 2'b11;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!(in_frame && k == 1 + 2 * OSR) && cyc < 50) begin
         tick();
         cyc++;
      end
      check("abort_reach", k, 1 + 2 * OSR);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sym_valid = 1'b0;
      repeat (6) tick();
      check("abort_done", n_done, 0);
      check("abort_last", n_last, 0);
      check("abort_idle", 32'(busy), 0);
      clr_cnt();
      run_frame(4, 1, 200);
      check("fresh_samples", n_valid, 64);
      repeat (4) tick();

      clr_cnt();
      run_frame(3, 2, 400);
      check("b2b_samples", n_valid, 128);
      check("b2b_last", n_last, 2);
      repeat (4) tick();

      for (int f = 0; f < 3; f++) begin
         clr_cnt();
         run_frame(4, 1, 200);
         check("rand_samples", n_valid, 64);
         repeat (1 + $urandom_range(0, 3)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
